// File: rtl/regfile_wb_arb_pkg.sv
// Shared types for the write-back arbiter: requester identity and the rd/data bundle
// carried from the winning port to the register-file write stage.
package regfile_wb_arb_pkg;

   localparam int XLEN_DEF = 32;
   localparam int RD_W     = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   typedef struct packed {
      logic [RD_W-1:0]     rd;
      logic [XLEN_DEF-1:0] data;
   } wb_t;

endpackage

// File: rtl/regfile_wb_arb_rr_arb2.sv
// Two-way round-robin grant, combinational from the requests and pointer; no grant in reset.
// Pointer moves to the loser after every grant, so a held request is served next cycle.
module rr_arb2
   import regfile_wb_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_alu,
   input  logic req_mem,
   output logic gnt_alu,
   output logic gnt_mem
);

   req_e ptr_q;
   req_e ptr_d;

   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      ptr_d   = ptr_q;
      if (!reset) begin
         if (req_alu && req_mem) begin
            gnt_alu = (ptr_q == REQ_ALU);
            gnt_mem = (ptr_q == REQ_MEM);
         end else begin
            gnt_alu = req_alu;
            gnt_mem = req_mem;
         end
      end
      if (gnt_alu) begin
         ptr_d = REQ_MEM;
      end else if (gnt_mem) begin
         ptr_d = REQ_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= REQ_MEM;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arb.sv
// ALU/load write-back arbiter: one accept per cycle, register-file write one cycle later.
// The losing requester sees ready low and holds; busy scoreboard tracks issued-but-unwritten rd.
module regfile_wb_arb
   import regfile_wb_arb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid,
   input  logic [4:0]       alu_rd,
   input  logic [XLEN-1:0]  alu_data,
   output logic             alu_ready,
   input  logic             mem_valid,
   input  logic [4:0]       mem_rd,
   input  logic [XLEN-1:0]  mem_data,
   output logic             mem_ready,
   input  logic             issue_en,
   input  logic [4:0]       issue_rd,
   output logic [NREGS-1:0] busy,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata
);

   logic gnt_alu;
   logic gnt_mem;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_alu (alu_valid),
      .req_mem (mem_valid),
      .gnt_alu (gnt_alu),
      .gnt_mem (gnt_mem)
   );

   assign alu_ready = gnt_alu;
   assign mem_ready = gnt_mem;

   wb_t              wb_sel;
   wb_t              wb_q;
   wb_t              wb_d;
   logic             rf_we_q;
   logic             rf_we_d;
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      wb_sel = '0;
      if (gnt_alu) begin
         wb_sel.rd   = alu_rd;
         wb_sel.data = XLEN_DEF'(alu_data);
      end else if (gnt_mem) begin
         wb_sel.rd   = mem_rd;
         wb_sel.data = XLEN_DEF'(mem_data);
      end
   end

   // Writes to x0 are accepted but dropped; address/data only move on a real write.
   always_comb begin
      rf_we_d = (gnt_alu || gnt_mem) && (wb_sel.rd != '0);
      wb_d    = rf_we_d ? wb_sel : wb_q;
   end

   // Clear is applied before set so an issue in the retiring cycle keeps the bit.
   always_comb begin
      busy_d = busy_q;
      for (int k = 1; k < NREGS; k++) begin
         if (rf_we_q && (wb_q.rd == RD_W'(k))) begin
            busy_d[k] = 1'b0;
         end
         if (issue_en && (issue_rd == RD_W'(k))) begin
            busy_d[k] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q <= 1'b0;
         wb_q    <= '0;
         busy_q  <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         wb_q    <= wb_d;
         busy_q  <= busy_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = wb_q.rd;
   assign rf_wdata = XLEN'(wb_q.data);
   assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations at the scenario points.
module tb_regfile_wb_arb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             alu_valid;
   logic [4:0]       alu_rd;
   logic [XLEN-1:0]  alu_data;
   logic             alu_ready;
   logic             mem_valid;
   logic [4:0]       mem_rd;
   logic [XLEN-1:0]  mem_data;
   logic             mem_ready;
   logic             issue_en;
   logic [4:0]       issue_rd;
   logic [NREGS-1:0] busy;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [XLEN-1:0]  rf_wdata;

   regfile_wb_arb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .issue_en  (issue_en),
      .issue_rd  (issue_rd),
      .busy      (busy),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: whose turn it is, the pending register-file write, the pending-write set.
   bit               m_turn_mem;
   bit               m_we;
   int               m_waddr;
   logic [XLEN-1:0]  m_wdata;
   logic [NREGS-1:0] m_busy;

   function automatic bit exp_alu_rdy();
      if (reset) return 1'b0;
      if (alu_valid && mem_valid) return !m_turn_mem;
      return alu_valid;
   endfunction

   function automatic bit exp_mem_rdy();
      if (reset) return 1'b0;
      if (alu_valid && mem_valid) return m_turn_mem;
      return mem_valid;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (check_en) begin
            chk("alu_ready", 64'(alu_ready), 64'(exp_alu_rdy()));
            chk("mem_ready", 64'(mem_ready), 64'(exp_mem_rdy()));
            chk("rf_we",     64'(rf_we),     64'(m_we));
            chk("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
            chk("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
            chk("busy",      64'(busy),      64'(m_busy));
         end
         @(posedge clk);
         if (reset) begin
            m_turn_mem = 1'b1;
            m_we       = 1'b0;
            m_waddr    = 0;
            m_wdata    = '0;
            m_busy     = '0;
         end else begin
            bit a_win;
            bit m_win;
            a_win = exp_alu_rdy();
            m_win = exp_mem_rdy();
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (a_win) m_turn_mem = 1'b1;
            if (m_win) m_turn_mem = 1'b0;
            m_we = 1'b0;
            if (a_win && alu_rd != 0) begin
               m_we = 1'b1; m_waddr = alu_rd; m_wdata = alu_data;
            end else if (m_win && mem_rd != 0) begin
               m_we = 1'b1; m_waddr = mem_rd; m_wdata = mem_data;
            end
         end
      end
   end

   // One cycle: inputs change at the falling edge, literal checks follow 4 ns later.
   task automatic cyc(input logic rst,
                      input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                      input logic ie, input logic [4:0] ird);
      @(negedge clk);
      reset = rst;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      issue_en = ie;  issue_rd = ird;
      #4;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
   endtask

   initial begin
      reset = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      issue_en = 1'b0; issue_rd = '0;
      repeat (2) @(posedge clk);
      check_en = 1'b1;

      // Requests during reset are never accepted.
      cyc(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      idle();
      chk("post_rst_we",    64'(rf_we),    64'd0);
      chk("post_rst_waddr", 64'(rf_waddr), 64'd0);
      chk("post_rst_busy",  64'(busy),     64'd0);

      // Lone load write-back.
      cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      chk("mem_only_ready", 64'(mem_ready), 64'd1);
      idle();
      chk("mem_wb_we",    64'(rf_we),    64'd1);
      chk("mem_wb_waddr", 64'(rf_waddr), 64'd5);
      chk("mem_wb_wdata", 64'(rf_wdata), 64'hDEADBEEF);

      // ALU write to x0: consumed, no write, outputs hold.
      cyc(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      chk("x0_alu_ready", 64'(alu_ready), 64'd1);
      idle();
      chk("x0_we",         64'(rf_we),    64'd0);
      chk("x0_hold_waddr", 64'(rf_waddr), 64'd5);
      chk("x0_hold_wdata", 64'(rf_wdata), 64'hDEADBEEF);

      // Both held four cycles with MEM's turn first: MEM, ALU, MEM, ALU.
      for (int i = 0; i < 5; i++) begin
         if (i < 4) cyc(1'b0, 1'b1, 5'd1, 32'h11110001, 1'b1, 5'd2, 32'h22220002, 1'b0, 5'd0);
         else       idle();
         if (i < 4) begin
            chk("rr_mem_ready", 64'(mem_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_alu_ready", 64'(alu_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
         end
         if (i > 0) begin
            chk("rr_we",    64'(rf_we),    64'd1);
            chk("rr_waddr", 64'(rf_waddr), ((i - 1) % 2 == 0) ? 64'd2 : 64'd1);
         end
      end

      // Scoreboard set on issue, clear on write, set wins over a same-cycle clear.
      cyc(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
      idle();
      chk("sb_set", 64'(busy), 64'h80);
      cyc(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      chk("sb_hold_accept", 64'(busy), 64'h80);
      idle();
      chk("sb_we",         64'(rf_we),    64'd1);
      chk("sb_waddr",      64'(rf_waddr), 64'd7);
      chk("sb_hold_write", 64'(busy),     64'h80);
      idle();
      chk("sb_cleared", 64'(busy), 64'h0);
      cyc(1'b0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, '0, 1'b0, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
      chk("sb_race_we", 64'(rf_we), 64'd1);
      idle();
      chk("sb_set_wins", 64'(busy), 64'h80);

      // Reset right after an accept drops the pending write and state.
      cyc(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
      chk("mr_mem_ready", 64'(mem_ready), 64'd1);
      cyc(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
      chk("mr_alu_ready", 64'(alu_ready), 64'd0);
      chk("mr_mem_ready_rst", 64'(mem_ready), 64'd0);
      cyc(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
      chk("mr_we",       64'(rf_we),     64'd0);
      chk("mr_busy",     64'(busy),      64'd0);
      chk("mr_ptr_mem",  64'(mem_ready), 64'd1);
      cyc(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd0);
      chk("mr_we2",    64'(rf_we),    64'd1);
      chk("mr_waddr2", 64'(rf_waddr), 64'd6);
      idle();
      chk("issue_x0_busy", 64'(busy), 64'd0);

      idle();
      idle();
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
